// File: rtl/sha_farm_ctrl.sv
// Host-side bus master for the SHA farm: writes a job's payload into one plant,
// waits for its result, reads the result words back and streams them upstream.
module sha_farm_ctrl #(
    parameter int WIDTH_ADD  = 5,
    parameter int WIDTH_FARM = 16,
    parameter int N_WR       = 4,
    parameter int N_RD       = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [WIDTH_ADD-1:0]  cmd_row_i,
    input  logic [WIDTH_ADD-1:0]  cmd_col_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH_FARM-1:0] in_data_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [WIDTH_FARM-1:0] res_data_o,
    output logic                  res_last_o,
    output logic                  err_timeout_o,
    output logic [WIDTH_ADD-1:0]  writerow_o,
    output logic [WIDTH_ADD-1:0]  writecol_o,
    output logic [WIDTH_ADD-1:0]  readrow_o,
    output logic [WIDTH_ADD-1:0]  readcol_o,
    inout  wire  [WIDTH_FARM-1:0] farmdata_io,
    input  logic                  farmwrite_i,
    input  logic                  farmbusy_i
);

    localparam int CNT_MAX = (N_WR > N_RD) ? N_WR : N_RD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] W_LAST = CW'(N_WR - 1);
    localparam logic [CW-1:0] R_LAST = CW'(N_RD - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, TURN, WAIT, READ, RESP} state_t;

    state_t               state;
    logic [WIDTH_ADD-1:0] row;
    logic [WIDTH_ADD-1:0] col;
    logic [CW-1:0]        wcnt;
    logic [CW-1:0]        rcnt;
    logic [TW-1:0]        tcnt;
    logic                 drive;

    // The bus is only ever driven during an accepted write beat, so a farm that
    // takes the bus (farmwrite_i) or is busy can never see contention from us.
    assign in_ready_o  = (state == WRITE) & ~farmbusy_i & ~farmwrite_i;
    assign drive       = in_ready_o & in_valid_i;
    assign farmdata_io = drive ? in_data_i : {WIDTH_FARM{1'bz}};

    // State decodes are gated by reset so every output reads 0 while it is held.
    assign cmd_ready_o = (state == IDLE) & rst_i;
    assign res_valid_o = (state == RESP);
    assign res_last_o  = (state == RESP) & (rcnt == R_LAST);

    always_comb begin
        writerow_o = '0;
        writecol_o = '0;
        readrow_o  = '0;
        readcol_o  = '0;
        if (state == WRITE) begin
            writerow_o = row;
            writecol_o = col;
        end
        if (state == WAIT || state == READ) begin
            readrow_o = row;
            readcol_o = col;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            wcnt          <= '0;
            rcnt          <= '0;
            tcnt          <= '0;
            res_data_o    <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            err_timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        row   <= cmd_row_i;
                        col   <= cmd_col_i;
                        wcnt  <= '0;
                        rcnt  <= '0;
                        tcnt  <= '0;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (drive) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == W_LAST) state <= TURN;
                    end
                end
                TURN: state <= WAIT;
                WAIT: begin
                    // A result arriving on the final cycle takes priority over the abort.
                    if (farmwrite_i) begin
                        state <= READ;
                    end else if (tcnt == T_LAST) begin
                        err_timeout_o <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                READ: begin
                    if (farmwrite_i) begin
                        res_data_o <= farmdata_io;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready_i) begin
                        rcnt  <= rcnt + 1'b1;
                        state <= (rcnt == R_LAST) ? IDLE : READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
